xor_stream_encryptor: RTL and testbench

Downstream consumer of the 512-bit key assembler in the XOR cipher datapath. Once the assembled key is flagged ready, it accepts 32-bit plaintext words from the data deserializer and XORs each word with the next 32-bit key segment, rotating through all 16 segments. It then shifts the ciphertext out one bit per clock, MSB first, on a single output pin.

---
 rtl/xor_cipher_pkg.sv | 37 +++
 rtl/cipher_shift_register.sv | 52 +++++
 rtl/xor_stream_encryptor.sv | 144 ++++++++++++++
 tb/tb_xor_stream_encryptor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared constants, state encoding and key-segment helper for the XOR cipher datapath.
package xor_cipher_pkg;

    localparam int KEY_WIDTH    = 512;
    localparam int WORD_WIDTH   = 32;
    localparam int NUM_SEGMENTS = 16;
    localparam int SEG_IDX_W    = 4;
    localparam int BIT_CNT_W    = 5;
    localparam int DESER_CNT_W  = 6;

    // Deserializer bit count that marks iData as a complete word.
    localparam logic [DESER_CNT_W-1:0] WORD_COMPLETE = 6'd32;

    // Last bit position of a word, loaded into the shift down-counter.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT_POS = 5'd31;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } enc_state_e;

    // Segment k of the key occupies bits [32k+31 : 32k].
    function automatic logic [WORD_WIDTH-1:0] key_segment(
        input logic [KEY_WIDTH-1:0] key,
        input logic [SEG_IDX_W-1:0] idx
    );
        logic [WORD_WIDTH-1:0] seg;
        seg = '0;
        for (int i = 0; i < NUM_SEGMENTS; i++) begin
            if (idx == SEG_IDX_W'(i)) begin
                seg = key[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
        return seg;
    endfunction

endpackage

// File: rtl/cipher_shift_register.sv
// 32-bit parallel-load, shift-left ciphertext register with a 5-bit bit-position
// down-counter. last_o is high while the bit currently on msb_o is bit 0 of the word.
// Priority: clear, then load, then shift.
module cipher_shift_register
    import xor_cipher_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [WORD_WIDTH-1:0] load_data_i,
    output logic                  msb_o,
    output logic                  last_o
);

    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic [BIT_CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state: abort clears, load primes a full word, shift moves the next bit up.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            data_d = '0;
            cnt_d  = '0;
        end else if (load_i) begin
            data_d = load_data_i;
            cnt_d  = LAST_BIT_POS;
        end else if (shift_i) begin
            data_d = {data_q[WORD_WIDTH-2:0], 1'b0};
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign msb_o  = data_q[WORD_WIDTH-1];
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/xor_stream_encryptor.sv
// XOR stream encryptor: XORs each accepted plaintext word with the next 32-bit key
// segment (rotating through 16) and shifts the ciphertext out MSB first.
// Optional build macro XOR_STREAM_PARALLEL_OUT_EN adds a parallel ciphertext word port.
//
// Handshake: a word is accepted on the clock edge where iBit_counter_data has just
// become 32 (it was not 32 on the previous edge) while iCan_encrypt is high. There is
// no back-pressure; an accept that arrives while a word is still shifting (bit count
// not 0) is dropped and flagged on the sticky oOverrun. oCipher_valid qualifies
// oCipher_bit, and oWord_done marks the last bit of each word.
module xor_stream_encryptor
    import xor_cipher_pkg::*;
(
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic [KEY_WIDTH-1:0]   iAssembled_key,
    input  logic                   iCan_encrypt,
    input  logic [WORD_WIDTH-1:0]  iData,
    input  logic [DESER_CNT_W-1:0] iBit_counter_data,
    output logic                   oCipher_bit,
    output logic                   oCipher_valid,
    output logic                   oWord_done,
    output logic [SEG_IDX_W-1:0]   oSegment_index,
    output logic                   oBusy,
    output logic                   oOverrun
`ifdef XOR_STREAM_PARALLEL_OUT_EN
    ,
    output logic [WORD_WIDTH-1:0]  oCipher_word,
    output logic                   oCipher_word_valid
`endif
);

    enc_state_e            state_q, state_d;
    logic [SEG_IDX_W-1:0]  seg_q, seg_d;
    logic                  ovr_q, ovr_d;
    logic                  full_q;

    logic                  full_now;
    logic                  accept;
    logic                  sr_load, sr_shift, sr_clear;
    logic                  sr_msb, sr_last;
    logic [SEG_IDX_W-1:0]  load_seg;
    logic [WORD_WIDTH-1:0] load_word;

    assign full_now  = (iBit_counter_data == WORD_COMPLETE);
    assign accept    = full_now && !full_q && iCan_encrypt;
    assign load_word = iData ^ key_segment(iAssembled_key, load_seg);

    // FSM next-state, segment rotation and overrun detection.
    always_comb begin
        state_d  = state_q;
        seg_d    = seg_q;
        ovr_d    = ovr_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_clear = 1'b0;
        load_seg = seg_q;
        if (!iCan_encrypt) begin
            // Key withdrawn: abandon the word and restart the segment rotation.
            state_d  = IDLE;
            seg_d    = '0;
            sr_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sr_load = 1'b1;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_shift = 1'b1;
                    if (sr_last) begin
                        seg_d = seg_q + 4'd1;
                        if (accept) begin
                            // Back-to-back word picks up the freshly advanced segment.
                            sr_load  = 1'b1;
                            load_seg = seg_q + 4'd1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (accept) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, segment index, overrun and counter edge-flag registers.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= IDLE;
            seg_q   <= '0;
            ovr_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
            ovr_q   <= ovr_d;
            full_q  <= full_now;
        end
    end

    cipher_shift_register u_shift (
        .clk_i       (iClk),
        .rst_ni      (iRst),
        .clear_i     (sr_clear),
        .load_i      (sr_load),
        .shift_i     (sr_shift),
        .load_data_i (load_word),
        .msb_o       (sr_msb),
        .last_o      (sr_last)
    );

    assign oCipher_bit    = sr_msb;
    assign oCipher_valid  = (state_q == SHIFT);
    assign oBusy          = (state_q == SHIFT);
    assign oWord_done     = (state_q == SHIFT) && sr_last;
    assign oSegment_index = seg_q;
    assign oOverrun       = ovr_q;

`ifdef XOR_STREAM_PARALLEL_OUT_EN
    logic [WORD_WIDTH-1:0] word_q;
    logic                  word_valid_q;

    // Capture the full ciphertext word alongside every load, one-cycle valid pulse.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= sr_load;
            if (sr_load) begin
                word_q <= load_word;
            end
        end
    end

    assign oCipher_word       = word_q;
    assign oCipher_word_valid = word_valid_q;
`endif

endmodule

// File: tb/tb_xor_stream_encryptor.sv
// Directed testbench for xor_stream_encryptor with a queue-based serial scoreboard.
module tb_xor_stream_encryptor;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic [511:0] iAssembled_key = '0;
    logic         iCan_encrypt = 1'b0;
    logic [31:0]  iData = '0;
    logic [5:0]   iBit_counter_data = '0;
    logic         oCipher_bit;
    logic         oCipher_valid;
    logic         oWord_done;
    logic [3:0]   oSegment_index;
    logic         oBusy;
    logic         oOverrun;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_q[$];
    logic [31:0]  exp_word;
    logic [31:0]  shreg = '0;
    int           nbits = 0;
    int           run_len = 0;
    int           last_run = 0;
    int           words_done = 0;

    xor_stream_encryptor dut (
        .iClk              (iClk),
        .iRst              (iRst),
        .iAssembled_key    (iAssembled_key),
        .iCan_encrypt      (iCan_encrypt),
        .iData             (iData),
        .iBit_counter_data (iBit_counter_data),
        .oCipher_bit       (oCipher_bit),
        .oCipher_valid     (oCipher_valid),
        .oWord_done        (oWord_done),
        .oSegment_index    (oSegment_index),
        .oBusy             (oBusy),
        .oOverrun          (oOverrun)
    );

    // Clock
    always #5 iClk = ~iClk;

    // Watchdog: the run is bounded even if the design stalls.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Present a complete word for exactly one edge (call at a negedge).
    task automatic pulse_word(input logic [31:0] d);
        iData             = d;
        iBit_counter_data = 6'd32;
        @(negedge iClk);
        iBit_counter_data = 6'd0;
    endtask

    task automatic set_key_rotation();
        for (int k = 0; k < 16; k++) begin
            iAssembled_key[k*32 +: 32] = 32'(k);
        end
    endtask

    // Monitor / scoreboard: rebuild each serial word and compare against the queue.
    always @(negedge iClk) begin
        if (oCipher_valid) begin
            shreg = {shreg[30:0], oCipher_bit};
            nbits++;
            run_len++;
            if (oWord_done) begin
                words_done++;
                check("word_done_cycle", 32'(nbits), 32'd32);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", shreg);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("cipher_word", shreg, exp_word);
                end
                nbits = 0;
            end
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            nbits   = 0;
        end
    end

    initial begin
        logic seen;
        int   base;

        // Reset state
        #1 iRst = 1'b0;
        repeat (2) @(negedge iClk);
        check("reset_outputs", 32'({oCipher_bit, oCipher_valid, oWord_done, oSegment_index, oBusy, oOverrun}), 32'd0);
        iRst         = 1'b1;
        iCan_encrypt = 1'b1;
        @(negedge iClk);
        check("idle_after_reset", 32'({oCipher_valid, oWord_done, oBusy}), 32'd0);

        // Single word: 0xFFFF0000 ^ 0xA5A5A5A5 = 0x5A5AA5A5
        iAssembled_key[31:0] = 32'hA5A5A5A5;
        exp_q.push_back(32'h5A5AA5A5);
        pulse_word(32'hFFFF0000);
        check("first_bit", 32'({oCipher_valid, oCipher_bit}), 32'b10);
        @(negedge iClk);
        check("second_bit", 32'({oCipher_valid, oCipher_bit}), 32'b11);
        repeat (31) @(negedge iClk);
        check("single_seg_index", 32'(oSegment_index), 32'd1);
        check("single_idle", 32'({oCipher_valid, oBusy}), 32'd0);

        // Reset mid-word: outputs clear before the next clock edge
        set_key_rotation();
        pulse_word(32'h12340000);
        repeat (9) @(negedge iClk);
        check("pre_reset_busy", 32'({oCipher_valid, oBusy}), 32'b11);
        #2 iRst = 1'b0;
        #1;
        check("async_reset_outputs", 32'({oCipher_bit, oCipher_valid, oWord_done, oSegment_index, oBusy, oOverrun}), 32'd0);
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);

        // Rotation: 17 zero words, segment k = k
        for (int k = 0; k < 17; k++) begin
            exp_q.push_back(32'(k % 16));
            pulse_word(32'h00000000);
            repeat (32) @(negedge iClk);
            check("rot_seg_index", 32'(oSegment_index), 32'((k + 1) % 16));
        end

        // Back-to-back words (segments 1 and 2) plus a dropped third word
        exp_q.push_back(32'h12345679);
        exp_q.push_back(32'hCAFEBABC);
        pulse_word(32'h12345678);
        repeat (31) @(negedge iClk);
        pulse_word(32'hCAFEBABE);
        repeat (9) @(negedge iClk);
        check("overrun_clear_before", 32'(oOverrun), 32'd0);
        pulse_word(32'hDEADBEEF);
        check("overrun_set", 32'(oOverrun), 32'd1);
        repeat (23) @(negedge iClk);
        check("b2b_contiguous", 32'(last_run), 32'd64);
        check("b2b_seg_index", 32'(oSegment_index), 32'd3);
        check("overrun_sticky", 32'(oOverrun), 32'd1);

        // Gating: complete word while key not ready produces nothing
        iCan_encrypt      = 1'b0;
        iData             = 32'h55555555;
        iBit_counter_data = 6'd32;
        seen              = 1'b0;
        repeat (5) begin
            @(negedge iClk);
            if (oCipher_valid || oWord_done) seen = 1'b1;
        end
        check("gated_no_output", 32'(seen), 32'd0);
        check("gated_seg_index", 32'(oSegment_index), 32'd0);
        iBit_counter_data = 6'd0;
        @(negedge iClk);
        iCan_encrypt = 1'b1;
        @(negedge iClk);

        // Abort at cycle 16 of a word
        pulse_word(32'h00FF00FF);
        repeat (15) @(negedge iClk);
        check("abort_pre_valid", 32'(oCipher_valid), 32'd1);
        iCan_encrypt = 1'b0;
        @(negedge iClk);
        check("abort_outputs", 32'({oCipher_valid, oWord_done, oBusy}), 32'd0);
        check("abort_seg_index", 32'(oSegment_index), 32'd0);
        check("abort_overrun_held", 32'(oOverrun), 32'd1);
        iCan_encrypt = 1'b1;
        @(negedge iClk);

        // Level-held counter after reset: exactly one word, no overrun
        iRst = 1'b0;
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        check("overrun_reset", 32'(oOverrun), 32'd0);
        base = words_done;
        exp_q.push_back(32'h0F0F0F0F);
        iData             = 32'h0F0F0F0F;
        iBit_counter_data = 6'd32;
        repeat (40) @(negedge iClk);
        iBit_counter_data = 6'd0;
        repeat (5) @(negedge iClk);
        check("held_one_word", 32'(words_done - base), 32'd1);
        check("held_no_overrun", 32'(oOverrun), 32'd0);
        check("held_seg_index", 32'(oSegment_index), 32'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
